// File: rtl/data_memory_bhw.sv
// Byte/halfword/word data memory with misalignment rejection and optional post-reset zero-fill.
// Loads return one cycle later with a ReadValid pulse; there is no backpressure and requests are dropped while Busy.
module data_memory_bhw #(
  parameter int DEPTH          = 1024,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  AccessSize,
  input  logic        SignExtend,
  output logic [31:0] ReadData,
  output logic        ReadValid,
  output logic        Misaligned,
  output logic        Busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;
  localparam state_t RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

  typedef struct packed {
    logic          en;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   dat;
  } wr_req_t;

  state_t        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic [31:0]   read_data_q, read_data_d;
  logic          read_valid_q, read_valid_d;
  logic          misaligned_q, misaligned_d;

  logic [31:0]   mem_q [DEPTH];
  wr_req_t       wr;

  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic [31:0]   rword;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_dat;
  logic [3:0]    st_be;
  logic [31:0]   st_dat;
  logic          misal;
  logic          addr_unused;

  assign word_idx    = Address[AW+1:2];
  assign lane        = Address[1:0];
  assign rword       = mem_q[word_idx];
  assign addr_unused = ^Address[31:AW+2];

  // Lane steering for loads and stores; store data is replicated so the byte enables pick the lanes.
  always_comb begin
    ld_half = Address[1] ? rword[31:16] : rword[15:0];
    case (lane)
      2'd0:    ld_byte = rword[7:0];
      2'd1:    ld_byte = rword[15:8];
      2'd2:    ld_byte = rword[23:16];
      default: ld_byte = rword[31:24];
    endcase

    case (AccessSize)
      2'b00: begin
        ld_dat = SignExtend ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
        st_be  = 4'b0001 << lane;
        st_dat = {4{WriteData[7:0]}};
        misal  = 1'b0;
      end
      2'b01: begin
        ld_dat = SignExtend ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
        st_be  = Address[1] ? 4'b1100 : 4'b0011;
        st_dat = {2{WriteData[15:0]}};
        misal  = Address[0];
      end
      default: begin
        ld_dat = rword;
        st_be  = 4'b1111;
        st_dat = WriteData;
        misal  = |Address[1:0];
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    read_data_d  = read_data_q;
    read_valid_d = 1'b0;
    misaligned_d = 1'b0;
    wr           = '0;

    case (state_q)
      ST_CLEAR: begin
        wr.en     = 1'b1;
        wr.idx    = clr_cnt_q;
        wr.be     = 4'b1111;
        wr.dat    = '0;
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == AW'(DEPTH - 1)) begin
          state_d = ST_READY;
        end
      end
      default: begin
        if ((MemRead || MemWrite) && misal) begin
          misaligned_d = 1'b1;
        end else begin
          // The read uses the pre-edge array, so a same-cycle store is seen only by later loads.
          if (MemRead) begin
            read_valid_d = 1'b1;
            read_data_d  = ld_dat;
          end
          if (MemWrite) begin
            wr.en  = 1'b1;
            wr.idx = word_idx;
            wr.be  = st_be;
            wr.dat = st_dat;
          end
        end
      end
    endcase

    if (Reset) begin
      wr.en = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= RST_STATE;
      clr_cnt_q    <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      misaligned_q <= misaligned_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (wr.en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr.be[b]) begin
          mem_q[wr.idx][8*b +: 8] <= wr.dat[8*b +: 8];
        end
      end
    end
  end

  assign ReadData   = read_data_q;
  assign ReadValid  = read_valid_q;
  assign Misaligned = misaligned_q;
  assign Busy       = (state_q == ST_CLEAR);

endmodule
